csr_arbiter: RTL and testbench

CSR_ARBITER -- requirements
Module: csr_arbiter

---
 rtl/csr_arb_pkg.sv | 9 +
 rtl/csr_arbiter_rr_picker.sv | 31 +++
 rtl/csr_arbiter.sv | 109 ++++++++++
 tb/tb_csr_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_arb_pkg.sv
// Shared types for the CSR arbiter: FSM state encoding.
package csr_arb_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } arb_state_e;

endpackage

// File: rtl/csr_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after last_grant+1, wrapping.
// Zero latency; no state, no backpressure.
module rr_picker #(
  parameter int NumReq = 2,
  localparam int IdxW = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   last_grant_i,
  output logic [IdxW-1:0]   grant_o,
  output logic              grant_vld_o
);

  int              sum;
  logic [IdxW-1:0] idx;

  always_comb begin
    grant_o     = last_grant_i;
    grant_vld_o = 1'b0;
    sum         = 0;
    idx         = '0;
    for (int i = 1; i <= NumReq; i++) begin
      sum = int'(last_grant_i) + i;
      idx = IdxW'(sum % NumReq);
      if (!grant_vld_o && req_i[idx]) begin
        grant_vld_o = 1'b1;
        grant_o     = idx;
      end
    end
  end

endmodule

// File: rtl/csr_arbiter.sv
// Round-robin arbiter sharing one CSR port among NumReq requesters; grant in the request cycle.
// Writes complete on handshake; a read blocks all grants until its response handshake.
module csr_arbiter
  import csr_arb_pkg::*;
#(
  parameter int NumReq       = 2,
  parameter int CsrDataWidth = 32,
  parameter int CsrAddrWidth = 32,
  localparam int IdxW = $clog2(NumReq)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumReq-1:0][CsrDataWidth-1:0]  req_data_i,
  input  logic [NumReq-1:0][CsrAddrWidth-1:0]  req_addr_i,
  input  logic [NumReq-1:0]                    req_write_i,
  input  logic [NumReq-1:0]                    req_valid_i,
  output logic [NumReq-1:0]                    req_ready_o,
  output logic [NumReq-1:0][CsrDataWidth-1:0]  rsp_data_o,
  output logic [NumReq-1:0]                    rsp_valid_o,
  input  logic [NumReq-1:0]                    rsp_ready_i,
  output logic [CsrDataWidth-1:0]              csr_req_data_o,
  output logic [CsrAddrWidth-1:0]              csr_req_addr_o,
  output logic                                 csr_req_write_o,
  output logic                                 csr_req_valid_o,
  input  logic                                 csr_req_ready_i,
  input  logic [CsrDataWidth-1:0]              csr_rsp_data_i,
  input  logic                                 csr_rsp_valid_i,
  output logic                                 csr_rsp_ready_o,
  output logic [IdxW-1:0]                      grant_id_o
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] last_grant_q, last_grant_d;
  logic [IdxW-1:0] pick;
  logic            pick_vld;

  rr_picker #(.NumReq(NumReq)) u_picker (
    .req_i        (req_valid_i),
    .last_grant_i (last_grant_q),
    .grant_o      (pick),
    .grant_vld_o  (pick_vld)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_grant_q <= LastIdx;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_grant_d    = last_grant_q;
    req_ready_o     = '0;
    rsp_data_o      = '0;
    rsp_valid_o     = '0;
    csr_req_data_o  = '0;
    csr_req_addr_o  = '0;
    csr_req_write_o = 1'b0;
    csr_req_valid_o = 1'b0;
    csr_rsp_ready_o = 1'b0;
    grant_id_o      = last_grant_q;

    // Outputs are forced quiet while reset is held, even if requesters are already valid.
    if (rst_i) begin
      grant_id_o = LastIdx;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_id_o          = pick;
            csr_req_valid_o     = 1'b1;
            csr_req_data_o      = req_data_i[pick];
            csr_req_addr_o      = req_addr_i[pick];
            csr_req_write_o     = req_write_i[pick];
            req_ready_o[pick]   = csr_req_ready_i;
            if (csr_req_ready_i) begin
              last_grant_d = pick;
              if (!req_write_i[pick]) begin
                state_d = WAIT_RSP;
                owner_d = pick;
              end
            end
          end
        end
        WAIT_RSP: begin
          grant_id_o           = owner_q;
          rsp_valid_o[owner_q] = csr_rsp_valid_i;
          rsp_data_o[owner_q]  = csr_rsp_data_i;
          csr_rsp_ready_o      = rsp_ready_i[owner_q];
          if (csr_rsp_valid_i && rsp_ready_i[owner_q]) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_arbiter.sv
// Scoreboard bench for csr_arbiter: directed scenarios then randomized traffic against a reference model.
module tb_csr_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int IW = $clog2(N);

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0][DW-1:0] req_data;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0]         req_write, req_valid, req_ready;
  logic [N-1:0][DW-1:0] rsp_data;
  logic [N-1:0]         rsp_valid, rsp_ready;
  logic [DW-1:0]        csr_req_data, csr_rsp_data;
  logic [AW-1:0]        csr_req_addr;
  logic                 csr_req_write, csr_req_valid, csr_req_ready;
  logic                 csr_rsp_valid, csr_rsp_ready;
  logic [IW-1:0]        grant_id;

  always #5 clk = ~clk;

  csr_arbiter #(.NumReq(N), .CsrDataWidth(DW), .CsrAddrWidth(AW)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_data_i(req_data), .req_addr_i(req_addr), .req_write_i(req_write),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .rsp_data_o(rsp_data), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .csr_req_data_o(csr_req_data), .csr_req_addr_o(csr_req_addr),
    .csr_req_write_o(csr_req_write), .csr_req_valid_o(csr_req_valid),
    .csr_req_ready_i(csr_req_ready),
    .csr_rsp_data_i(csr_rsp_data), .csr_rsp_valid_i(csr_rsp_valid),
    .csr_rsp_ready_o(csr_rsp_ready),
    .grant_id_o(grant_id)
  );

  typedef struct {
    bit            rst;
    logic          vld;
    logic [N-1:0]  rdy;
    logic [N-1:0]  rvld;
    logic [IW-1:0] gid;
    logic          crr;
    int            own;
    logic [DW-1:0] rdat;
  } cyc_t;

  typedef struct {
    int            id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          wr;
  } req_t;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
  } rsp_t;

  cyc_t cyc_q[$];
  req_t req_q[$];
  rsp_t rsp_q[$];
  int   grant_log[$];

  int checks   = 0;
  int failures = 0;

  // Reference model: transaction-level view of who owns the port.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_last  = N - 1;
  bit acc[N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_eval();
    cyc_t c;
    req_t r;
    rsp_t s;
    int   w;
    c.rst = rst; c.vld = 1'b0; c.rdy = '0; c.rvld = '0; c.gid = '0;
    c.crr = 1'b0; c.own = 0; c.rdat = '0;
    for (int k = 0; k < N; k++) acc[k] = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_owner = 0; m_last = N - 1;
      c.gid = IW'(N - 1);
    end else if (!m_busy) begin
      w = -1;
      for (int i = 1; i <= N; i++) begin
        if (w < 0 && req_valid[(m_last + i) % N]) w = (m_last + i) % N;
      end
      if (w < 0) begin
        c.gid = IW'(m_last);
      end else begin
        c.vld = 1'b1;
        c.gid = IW'(w);
        if (csr_req_ready) begin
          c.rdy = N'(1) << w;
          r.id = w; r.addr = req_addr[w]; r.data = req_data[w]; r.wr = req_write[w];
          req_q.push_back(r);
          acc[w] = 1'b1;
          m_last = w;
          if (!req_write[w]) begin
            m_busy  = 1'b1;
            m_owner = w;
          end
        end
      end
    end else begin
      c.gid  = IW'(m_owner);
      c.own  = m_owner;
      c.rvld = csr_rsp_valid ? (N'(1) << m_owner) : '0;
      c.rdat = csr_rsp_data;
      c.crr  = rsp_ready[m_owner];
      if (csr_rsp_valid && rsp_ready[m_owner]) begin
        s.id = m_owner; s.data = csr_rsp_data;
        rsp_q.push_back(s);
        m_busy = 1'b0;
      end
    end
    cyc_q.push_back(c);
  endfunction

  task automatic tick();
    model_eval();
    @(negedge clk);
  endtask

  // Monitor: samples 3 time units after the input-change edge, well clear of posedge.
  initial begin : monitor
    cyc_t c;
    req_t r;
    rsp_t s;
    forever begin
      @(negedge clk);
      #3;
      if (cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        check("csr_req_valid", 64'(csr_req_valid), 64'(c.vld));
        check("req_ready", 64'(req_ready), 64'(c.rdy));
        check("rsp_valid", 64'(rsp_valid), 64'(c.rvld));
        check("grant_id", 64'(grant_id), 64'(c.gid));
        check("csr_rsp_ready", 64'(csr_rsp_ready), 64'(c.crr));
        if (c.rvld != '0) check("rsp_data_route", 64'(rsp_data[c.own]), 64'(c.rdat));
        if (c.rst) begin
          check("rst_csr_req_data", 64'(csr_req_data), 64'(0));
          check("rst_csr_req_addr", 64'(csr_req_addr), 64'(0));
          check("rst_rsp_data", 64'(rsp_data), 64'(0));
        end
        if (csr_req_valid && csr_req_ready) begin
          grant_log.push_back(int'(grant_id));
          if (req_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL req_handshake: unexpected grant to %0d at %0t", grant_id, $time);
          end else begin
            r = req_q.pop_front();
            check("req_id", 64'(grant_id), 64'(r.id));
            check("req_addr", 64'(csr_req_addr), 64'(r.addr));
            check("req_data", 64'(csr_req_data), 64'(r.data));
            check("req_write", 64'(csr_req_write), 64'(r.wr));
          end
        end
        for (int k = 0; k < N; k++) begin
          if (rsp_valid[k] && rsp_ready[k]) begin
            if (rsp_q.size() == 0) begin
              checks++; failures++;
              $display("FAIL rsp_handshake: unexpected response to %0d at %0t", k, $time);
            end else begin
              s = rsp_q.pop_front();
              check("rsp_id", 64'(k), 64'(s.id));
              check("rsp_data", 64'(rsp_data[k]), 64'(s.data));
            end
          end
        end
      end
    end
  end

  task automatic quiet();
    req_valid = '0; req_write = '0; csr_req_ready = 1'b0;
    rsp_ready = '0; csr_rsp_valid = 1'b0; csr_rsp_data = '0;
  endtask

  initial begin : driver
    bit            have[N];
    logic [AW-1:0] t_addr[N];
    logic [DW-1:0] t_data[N];
    bit            t_wr[N];
    rst = 1'b1;
    req_data = '0; req_addr = '0;
    quiet();
    @(negedge clk);

    // Reset held with requesters already valid: outputs must stay quiet.
    req_valid = '1; req_write = '1; csr_req_ready = 1'b1;
    tick(); tick();
    rst = 1'b0; quiet();
    tick();

    // Single write from requester 0.
    req_valid = 2'b01; req_write[0] = 1'b1; req_addr[0] = 32'h3; req_data[0] = 32'h5;
    csr_req_ready = 1'b1;
    tick();
    quiet(); tick();

    // Read from requester 1, response next cycle.
    req_valid = 2'b10; req_write[1] = 1'b0; req_addr[1] = 32'h1; csr_req_ready = 1'b1;
    tick();
    quiet(); csr_rsp_valid = 1'b1; csr_rsp_data = 32'hA5; rsp_ready = 2'b11;
    tick();
    quiet(); tick();

    // Fairness after reset: both hold writes for 6 cycles.
    rst = 1'b1; tick(); rst = 1'b0;
    grant_log.delete();
    req_valid = 2'b11; req_write = 2'b11; csr_req_ready = 1'b1;
    req_addr[0] = 32'h10; req_addr[1] = 32'h20;
    repeat (6) tick();
    check("fair_count", 64'(grant_log.size()), 64'(6));
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      check("fair_order", 64'(grant_log[i]), 64'(i % 2));
    quiet(); tick();

    // Outstanding read from 0 blocks requester 1 while the owner stalls.
    req_valid = 2'b01; req_write[0] = 1'b0; csr_req_ready = 1'b1;
    tick();
    req_valid = 2'b10; req_write[1] = 1'b1; csr_rsp_valid = 1'b1; csr_rsp_data = 32'h77;
    rsp_ready = 2'b10;
    repeat (4) tick();
    rsp_ready = 2'b01;
    tick();
    csr_rsp_valid = 1'b0; rsp_ready = '0;
    grant_log.delete();
    tick();
    check("unblock_grant", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'(1));
    quiet(); tick();

    // Reset in the middle of a read, then a late response.
    req_valid = 2'b01; req_write[0] = 1'b0; csr_req_ready = 1'b1;
    tick();
    quiet(); rsp_ready = 2'b11; tick();
    rst = 1'b1; tick(); rst = 1'b0;
    csr_rsp_valid = 1'b1; csr_rsp_data = 32'hDEAD; rsp_ready = 2'b11;
    tick(); tick();
    quiet(); grant_log.delete();
    req_valid = 2'b11; req_write = 2'b11; csr_req_ready = 1'b1;
    tick();
    check("post_reset_grant", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'(0));
    quiet(); tick();

    // Randomized traffic, with dropped valids, spurious responses and occasional reset.
    for (int k = 0; k < N; k++) have[k] = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < N; k++) begin
        if (!have[k] && ($urandom % 3 == 0)) begin
          have[k] = 1'b1; t_addr[k] = $urandom; t_data[k] = $urandom; t_wr[k] = $urandom % 2;
        end
        req_valid[k] = have[k] && ($urandom % 4 != 0);
        req_addr[k]  = have[k] ? t_addr[k] : '0;
        req_data[k]  = have[k] ? t_data[k] : '0;
        req_write[k] = have[k] ? t_wr[k] : 1'b0;
        rsp_ready[k] = ($urandom % 3 != 0);
      end
      csr_req_ready = ($urandom % 4 != 0);
      csr_rsp_valid = m_busy ? ($urandom % 2 == 1) : ($urandom % 8 == 0);
      csr_rsp_data  = $urandom;
      rst = ($urandom % 300 == 0);
      tick();
      for (int k = 0; k < N; k++) if (acc[k]) have[k] = 1'b0;
    end
    rst = 1'b0; quiet();
    tick(); tick();
    check("req_queue_drained", 64'(req_q.size()), 64'(0));
    check("rsp_queue_drained", 64'(rsp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
